// File: rtl/addr_mode_seq.sv
// 6502-style group-one operand/effective-address sequencer.
// Fetches operand bytes at the PC, forms the EA, then issues the final read or store.
module addr_mode_seq #(
    parameter bit PAGE_PENALTY = 1'b1,
    parameter bit ZP_WRAP      = 1'b1,
    parameter bit DUMMY_RD     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  mode,
    input  logic        write,
    input  logic [7:0]  wdata,
    input  logic [15:0] pc_in,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [7:0]  d_in,
    output logic [15:0] addr,
    output logic [7:0]  d_out,
    output logic        rd,
    output logic        we,
    output logic        busy,
    output logic        done,
    output logic [15:0] ea,
    output logic [7:0]  operand,
    output logic [15:0] pc_out,
    output logic        page_cross
);

    localparam logic [2:0] M_IMM  = 3'd0;
    localparam logic [2:0] M_ZP   = 3'd1;
    localparam logic [2:0] M_ZPX  = 3'd2;
    localparam logic [2:0] M_ABS  = 3'd3;
    localparam logic [2:0] M_ABSX = 3'd4;
    localparam logic [2:0] M_ABSY = 3'd5;
    localparam logic [2:0] M_INDX = 3'd6;
    localparam logic [2:0] M_INDY = 3'd7;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_OP1    = 4'd1;
    localparam logic [3:0] S_OP2    = 4'd2;
    localparam logic [3:0] S_DUMMY  = 4'd3;
    localparam logic [3:0] S_PTR_LO = 4'd4;
    localparam logic [3:0] S_PTR_HI = 4'd5;
    localparam logic [3:0] S_FIX    = 4'd6;
    localparam logic [3:0] S_FINAL  = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    logic [3:0]  state;
    logic [2:0]  mode_r;
    logic        write_r;
    logic [7:0]  wdata_r;
    logic [15:0] pc_r;
    logic [7:0]  x_r, y_r;
    logic [7:0]  ptr_r, lo_r, hi_r;

    logic [7:0]  idx;
    logic [8:0]  sum;
    logic [15:0] idx_ea;
    logic [15:0] final_ea;
    logic [8:0]  off_lo, off_hi;
    logic        need_fix;
    logic        two_byte;
    logic        indexed;

    // Zero-page address with either 8-bit wrap or carry into the high byte.
    function automatic logic [15:0] zp_addr(input logic [7:0] base, input logic [8:0] off);
        logic [15:0] full;
        full = {8'h00, base} + {7'h00, off};
        return ZP_WRAP ? {8'h00, full[7:0]} : full;
    endfunction

    assign idx      = (mode_r == M_ABSX) ? x_r : y_r;
    assign sum      = {1'b0, lo_r} + {1'b0, idx};
    assign idx_ea   = {hi_r, lo_r} + {8'h00, idx};
    assign need_fix = PAGE_PENALTY && (write_r || sum[8]);
    assign off_lo   = (mode_r == M_INDX) ? {1'b0, x_r} : 9'd0;
    assign off_hi   = off_lo + 9'd1;
    assign two_byte = (mode_r == M_ABS) || (mode_r == M_ABSX) || (mode_r == M_ABSY);
    assign indexed  = (mode_r == M_ABSX) || (mode_r == M_ABSY) || (mode_r == M_INDY);

    always_comb begin
        final_ea = pc_r;
        case (mode_r)
            M_ZP:                  final_ea = {8'h00, lo_r};
            M_ZPX:                 final_ea = zp_addr(lo_r, {1'b0, x_r});
            M_ABS, M_INDX:         final_ea = {hi_r, lo_r};
            M_ABSX, M_ABSY, M_INDY: final_ea = idx_ea;
            default:               final_ea = pc_r;
        endcase
    end

    always_comb begin
        addr  = '0;
        rd    = 1'b0;
        we    = 1'b0;
        d_out = '0;
        case (state)
            S_OP1:    begin addr = pc_r;                    rd = 1'b1;     end
            S_OP2:    begin addr = pc_r + 16'd1;            rd = 1'b1;     end
            S_DUMMY:  begin addr = {8'h00, ptr_r};          rd = DUMMY_RD; end
            S_PTR_LO: begin addr = zp_addr(ptr_r, off_lo);  rd = 1'b1;     end
            S_PTR_HI: begin addr = zp_addr(ptr_r, off_hi);  rd = 1'b1;     end
            S_FIX:    begin addr = {hi_r, sum[7:0]};        rd = DUMMY_RD; end
            S_FINAL: begin
                addr  = final_ea;
                rd    = !write_r;
                we    = write_r;
                d_out = write_r ? wdata_r : 8'h00;
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            mode_r     <= '0;
            write_r    <= 1'b0;
            wdata_r    <= '0;
            pc_r       <= '0;
            x_r        <= '0;
            y_r        <= '0;
            ptr_r      <= '0;
            lo_r       <= '0;
            hi_r       <= '0;
            ea         <= '0;
            operand    <= '0;
            pc_out     <= '0;
            page_cross <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_r  <= mode;
                        write_r <= write;
                        wdata_r <= wdata;
                        pc_r    <= pc_in;
                        x_r     <= x;
                        y_r     <= y;
                        state   <= S_OP1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_OP1: begin
                    lo_r  <= d_in;
                    ptr_r <= d_in;
                    case (mode_r)
                        M_IMM: begin
                            // Immediate completes on the operand fetch; a store is never issued.
                            operand    <= d_in;
                            ea         <= pc_r;
                            pc_out     <= pc_r + 16'd1;
                            page_cross <= 1'b0;
                            state      <= S_DONE;
                        end
                        M_ZP:          state <= S_FINAL;
                        M_ZPX, M_INDX: state <= S_DUMMY;
                        M_INDY:        state <= S_PTR_LO;
                        default:       state <= S_OP2;
                    endcase
                end
                S_OP2: begin
                    hi_r <= d_in;
                    if (mode_r == M_ABS) state <= S_FINAL;
                    else                 state <= need_fix ? S_FIX : S_FINAL;
                end
                S_DUMMY:  state <= (mode_r == M_ZPX) ? S_FINAL : S_PTR_LO;
                S_PTR_LO: begin
                    lo_r  <= d_in;
                    state <= S_PTR_HI;
                end
                S_PTR_HI: begin
                    hi_r <= d_in;
                    if (mode_r == M_INDX) state <= S_FINAL;
                    else                  state <= need_fix ? S_FIX : S_FINAL;
                end
                S_FIX:    state <= S_FINAL;
                S_FINAL: begin
                    ea         <= final_ea;
                    pc_out     <= pc_r + (two_byte ? 16'd2 : 16'd1);
                    page_cross <= indexed && sum[8];
                    if (!write_r) operand <= d_in;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addr_mode_seq.sv
// Bench for addr_mode_seq: two instances (NMOS defaults / no-penalty, no-wrap, quiet dummies)
// checked every cycle against a bus-cycle list model built from the addressing-mode rules.
module tb_addr_mode_seq;

    typedef struct packed {
        logic [15:0] addr;
        logic        rd;
        logic        we;
        logic [7:0]  dout;
    } bus_t;

    typedef struct packed {
        logic [15:0] ea;
        logic [7:0]  op;
        logic [15:0] pco;
        logic        px;
        logic [7:0]  n;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  st;
    logic [2:0]  mode;
    logic        write;
    logic [7:0]  wdata;
    logic [15:0] pc_in;
    logic [7:0]  x, y;

    logic [7:0]  mem [65536];
    logic [7:0]  din      [2];
    logic [15:0] addr_o   [2];
    logic [7:0]  dout_o   [2];
    logic        rd_o     [2];
    logic        we_o     [2];
    logic        busy_o   [2];
    logic        done_o   [2];
    logic [15:0] ea_o     [2];
    logic [7:0]  op_o     [2];
    logic [15:0] pco_o    [2];
    logic        px_o     [2];

    int   checks = 0;
    int   errors = 0;
    int   sel = 0;
    int   cyc_cnt [2];
    res_t cur [2];
    logic [7:0] last_op [2];
    bus_t bq [$];
    res_t rq [$];

    always #5 clk = ~clk;

    assign din[0] = mem[addr_o[0]];
    assign din[1] = mem[addr_o[1]];

    addr_mode_seq #(.PAGE_PENALTY(1'b1), .ZP_WRAP(1'b1), .DUMMY_RD(1'b1)) dut0 (
        .clk(clk), .rst(rst), .start(st[0]), .mode(mode), .write(write), .wdata(wdata),
        .pc_in(pc_in), .x(x), .y(y), .d_in(din[0]), .addr(addr_o[0]), .d_out(dout_o[0]),
        .rd(rd_o[0]), .we(we_o[0]), .busy(busy_o[0]), .done(done_o[0]), .ea(ea_o[0]),
        .operand(op_o[0]), .pc_out(pco_o[0]), .page_cross(px_o[0]));

    addr_mode_seq #(.PAGE_PENALTY(1'b0), .ZP_WRAP(1'b0), .DUMMY_RD(1'b0)) dut1 (
        .clk(clk), .rst(rst), .start(st[1]), .mode(mode), .write(write), .wdata(wdata),
        .pc_in(pc_in), .x(x), .y(y), .d_in(din[1]), .addr(addr_o[1]), .d_out(dout_o[1]),
        .rd(rd_o[1]), .we(we_o[1]), .busy(busy_o[1]), .done(done_o[1]), .ea(ea_o[1]),
        .operand(op_o[1]), .pc_out(pco_o[1]), .page_cross(px_o[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] zp(input bit wrap, input logic [7:0] base, input logic [8:0] off);
        logic [15:0] f;
        f = {8'h00, base} + {7'h00, off};
        return wrap ? {8'h00, f[7:0]} : f;
    endfunction

    task automatic push(input logic [15:0] a, input logic r, input logic w, input logic [7:0] d);
        bus_t b;
        b.addr = a; b.rd = r; b.we = w; b.dout = d;
        bq.push_back(b);
    endtask

    // Expected bus cycles and results for one transaction on configuration c.
    task automatic model(input int c, input logic [2:0] m, input logic w, input logic [7:0] wd,
                         input logic [15:0] pc, input logic [7:0] xx, input logic [7:0] yy);
        bit pp, zw, fin;
        logic dr, px;
        logic [7:0] b1, lo, hi, idx;
        logic [15:0] a1, a2, e, pcn;
        logic [8:0] s;
        int n0;
        res_t r;
        pp = (c == 0); zw = (c == 0); dr = (c == 0);
        n0 = bq.size();
        fin = 1; px = 1'b0; pcn = pc + 16'd1; e = pc;
        b1 = mem[pc];
        push(pc, 1'b1, 1'b0, 8'h00);
        case (m)
            3'd0: fin = 0;
            3'd1: e = {8'h00, b1};
            3'd2: begin
                push({8'h00, b1}, dr, 1'b0, 8'h00);
                e = zp(zw, b1, {1'b0, xx});
            end
            3'd3: begin
                push(pc + 16'd1, 1'b1, 1'b0, 8'h00);
                e = {mem[pc + 16'd1], b1};
                pcn = pc + 16'd2;
            end
            3'd4, 3'd5: begin
                hi = mem[pc + 16'd1];
                push(pc + 16'd1, 1'b1, 1'b0, 8'h00);
                idx = (m == 3'd4) ? xx : yy;
                s = {1'b0, b1} + {1'b0, idx};
                px = s[8];
                e = {hi, b1} + {8'h00, idx};
                if (pp && (w || px)) push({hi, s[7:0]}, dr, 1'b0, 8'h00);
                pcn = pc + 16'd2;
            end
            3'd6: begin
                push({8'h00, b1}, dr, 1'b0, 8'h00);
                a1 = zp(zw, b1, {1'b0, xx});
                a2 = zp(zw, b1, {1'b0, xx} + 9'd1);
                push(a1, 1'b1, 1'b0, 8'h00);
                push(a2, 1'b1, 1'b0, 8'h00);
                e = {mem[a2], mem[a1]};
            end
            default: begin
                a1 = {8'h00, b1};
                a2 = zp(zw, b1, 9'd1);
                push(a1, 1'b1, 1'b0, 8'h00);
                push(a2, 1'b1, 1'b0, 8'h00);
                lo = mem[a1]; hi = mem[a2];
                s = {1'b0, lo} + {1'b0, yy};
                px = s[8];
                e = {hi, lo} + {8'h00, yy};
                if (pp && (w || px)) push({hi, s[7:0]}, dr, 1'b0, 8'h00);
            end
        endcase
        if (fin) begin
            push(e, !w, w, w ? wd : 8'h00);
            if (!w) last_op[c] = mem[e];
        end else begin
            last_op[c] = b1;
        end
        r.ea = e; r.op = last_op[c]; r.pco = pcn; r.px = px; r.n = 8'(bq.size() - n0);
        rq.push_back(r);
    endtask

    // Per-cycle comparison of both instances against the model queues.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rst) cyc_cnt[c] = 0;
            if (busy_o[c]) begin
                if (c == sel && bq.size() > 0) begin
                    bus_t b;
                    b = bq.pop_front();
                    cyc_cnt[c]++;
                    chk("bus_addr", 32'(addr_o[c]), 32'(b.addr));
                    chk("bus_rd",   32'(rd_o[c]),   32'(b.rd));
                    chk("bus_we",   32'(we_o[c]),   32'(b.we));
                    if (b.we) chk("bus_dout", 32'(dout_o[c]), 32'(b.dout));
                end else begin
                    chk("busy_unexp", 32'(busy_o[c]), 32'd0);
                end
            end else begin
                chk("idle_addr", 32'(addr_o[c]), 32'd0);
                chk("idle_rd",   32'(rd_o[c]),   32'd0);
                chk("idle_we",   32'(we_o[c]),   32'd0);
                if (done_o[c]) begin
                    if (c == sel && rq.size() > 0) begin
                        cur[c] = rq.pop_front();
                        chk("cycle_count", 32'(cyc_cnt[c]), 32'(cur[c].n));
                    end else begin
                        chk("done_unexp", 32'(done_o[c]), 32'd0);
                    end
                    cyc_cnt[c] = 0;
                end
                chk("res_ea", 32'(ea_o[c]),  32'(cur[c].ea));
                chk("res_op", 32'(op_o[c]),  32'(cur[c].op));
                chk("res_pc", 32'(pco_o[c]), 32'(cur[c].pco));
                chk("res_px", 32'(px_o[c]),  32'(cur[c].px));
            end
        end
    end

    // Returns in the done cycle, 1 time unit after its rising edge.
    task automatic run(input int c, input logic [2:0] m, input logic w, input logic [7:0] wd,
                       input logic [15:0] pc, input logic [7:0] xx, input logic [7:0] yy,
                       input bit hold, output int cyc);
        sel = c;
        model(c, m, w, wd, pc, xx, yy);
        mode = m; write = w; wdata = wd; pc_in = pc; x = xx; y = yy;
        st = 2'b00; st[c] = 1'b1;
        @(posedge clk); #1;
        if (!hold) st = 2'b00;
        chk("busy_c1", 32'(busy_o[c]), 32'd1);
        cyc = 0;
        while (!done_o[c] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done_o[c]) chk("done_timeout", 32'(done_o[c]), 32'd1);
        st = 2'b00;
    endtask

    task automatic idle(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bq.delete(); rq.delete();
        for (int c = 0; c < 2; c++) begin cur[c] = '0; last_op[c] = 8'h00; end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
        mem[16'h8000] = 8'hA9;
        mem[16'h0200] = 8'hF0; mem[16'h0010] = 8'h55; mem[16'h0110] = 8'hAA;
        mem[16'h0300] = 8'hFF; mem[16'h0301] = 8'h12; mem[16'h1300] = 8'h66;
        mem[16'h0310] = 8'h10; mem[16'h0311] = 8'h20;
        mem[16'h0320] = 8'hF0; mem[16'h0321] = 8'hFF;
        mem[16'h0400] = 8'hFE; mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12; mem[16'h1234] = 8'h9C;
        mem[16'h0500] = 8'h40; mem[16'h0040] = 8'hF0; mem[16'h0041] = 8'h07; mem[16'h0810] = 8'h3C;
        mem[16'h0520] = 8'hFF;
        mem[16'h0600] = 8'h33;
        mem[16'h0610] = 8'h34; mem[16'h0611] = 8'h12;
        st = 2'b00; mode = 3'd0; write = 1'b0; wdata = 8'h00; pc_in = 16'h0000; x = 8'h00; y = 8'h00;
        cyc_cnt[0] = 0; cyc_cnt[1] = 0;
        do_reset();
        #2;
        chk("rst_busy", 32'(busy_o[0]), 32'd0);
        chk("rst_done", 32'(done_o[0]), 32'd0);
        chk("rst_ea",   32'(ea_o[0]),   32'd0);
        chk("rst_pc",   32'(pco_o[0]),  32'd0);
        idle(2);
        rst = 1'b0;
        idle(2);

        run(0, 3'd0, 1'b0, 8'h00, 16'h8000, 8'h00, 8'h00, 0, n);
        chk("imm_cyc", 32'(n), 32'd1);
        chk("imm_op",  32'(op_o[0]),  32'hA9);
        chk("imm_ea",  32'(ea_o[0]),  32'h8000);
        chk("imm_pc",  32'(pco_o[0]), 32'h8001);
        idle(1);
        run(0, 3'd2, 1'b0, 8'h00, 16'h0200, 8'h20, 8'h00, 0, n);
        chk("zpx_cyc", 32'(n), 32'd3);
        chk("zpx_op",  32'(op_o[0]), 32'h55);
        idle(1);
        run(0, 3'd4, 1'b0, 8'h00, 16'h0300, 8'h00, 8'h00, 0, n);
        chk("absx0_cyc", 32'(n), 32'd3);
        chk("absx0_px",  32'(px_o[0]), 32'd0);
        idle(1);
        run(0, 3'd4, 1'b0, 8'h00, 16'h0300, 8'h01, 8'h00, 0, n);
        chk("absx_cyc", 32'(n), 32'd4);
        chk("absx_px",  32'(px_o[0]), 32'd1);
        chk("absx_op",  32'(op_o[0]), 32'h66);
        idle(1);
        run(0, 3'd5, 1'b1, 8'h77, 16'h0310, 8'h00, 8'h05, 0, n);
        chk("absyw_cyc", 32'(n), 32'd4);
        chk("absyw_ea",  32'(ea_o[0]), 32'h2015);
        chk("absyw_op",  32'(op_o[0]), 32'h66);
        idle(1);
        run(0, 3'd6, 1'b0, 8'h00, 16'h0400, 8'h01, 8'h00, 0, n);
        chk("indx_cyc", 32'(n), 32'd5);
        chk("indx_op",  32'(op_o[0]), 32'h9C);
        chk("indx_ea",  32'(ea_o[0]), 32'h1234);
        idle(1);
        run(0, 3'd7, 1'b0, 8'h00, 16'h0500, 8'h00, 8'h20, 0, n);
        chk("indy_cyc", 32'(n), 32'd5);
        chk("indy_ea",  32'(ea_o[0]), 32'h0810);
        chk("indy_op",  32'(op_o[0]), 32'h3C);
        idle(1);
        run(0, 3'd4, 1'b0, 8'h00, 16'h0320, 8'h20, 8'h00, 0, n);
        chk("wrap_ea", 32'(ea_o[0]), 32'h0010);
        chk("wrap_pc", 32'(pco_o[0]), 32'h0322);
        idle(1);
        run(0, 3'd1, 1'b0, 8'h00, 16'h0600, 8'h00, 8'h00, 0, n);
        chk("zp_cyc", 32'(n), 32'd2);
        idle(1);
        run(0, 3'd0, 1'b1, 8'h11, 16'h8000, 8'h00, 8'h00, 0, n);
        chk("immw_op", 32'(op_o[0]), 32'hA9);
        idle(1);
        run(0, 3'd7, 1'b1, 8'h5E, 16'h0500, 8'h00, 8'h00, 0, n);
        chk("indyw_cyc", 32'(n), 32'd5);
        idle(1);
        run(0, 3'd3, 1'b0, 8'h00, 16'h0610, 8'h00, 8'h00, 1, n);
        chk("hold_cyc", 32'(n), 32'd3);
        run(0, 3'd1, 1'b0, 8'h00, 16'h0600, 8'h00, 8'h00, 0, n);
        chk("b2b_cyc", 32'(n), 32'd2);
        idle(2);

        // Abort an INDX sequence in its third bus cycle.
        sel = 0;
        model(0, 3'd6, 1'b0, 8'h00, 16'h0400, 8'h01, 8'h00);
        mode = 3'd6; write = 1'b0; pc_in = 16'h0400; x = 8'h01; st = 2'b01;
        @(posedge clk); #1; st = 2'b00;
        idle(2);
        do_reset();
        #1;
        chk("abort_busy", 32'(busy_o[0]), 32'd0);
        chk("abort_addr", 32'(addr_o[0]), 32'd0);
        chk("abort_rd",   32'(rd_o[0]),   32'd0);
        chk("abort_done", 32'(done_o[0]), 32'd0);
        chk("abort_ea",   32'(ea_o[0]),   32'd0);
        chk("abort_op",   32'(op_o[0]),   32'd0);
        idle(2);
        rst = 1'b0;
        idle(3);
        run(0, 3'd6, 1'b0, 8'h00, 16'h0400, 8'h01, 8'h00, 0, n);
        chk("post_rst_op", 32'(op_o[0]), 32'h9C);
        idle(2);

        run(1, 3'd2, 1'b0, 8'h00, 16'h0200, 8'h20, 8'h00, 0, n);
        chk("nw_zpx_ea", 32'(ea_o[1]), 32'h0110);
        chk("nw_zpx_op", 32'(op_o[1]), 32'hAA);
        idle(1);
        run(1, 3'd4, 1'b0, 8'h00, 16'h0300, 8'h01, 8'h00, 0, n);
        chk("np_absx_cyc", 32'(n), 32'd3);
        chk("np_absx_op",  32'(op_o[1]), 32'h66);
        chk("np_absx_px",  32'(px_o[1]), 32'd1);
        idle(1);
        run(1, 3'd5, 1'b1, 8'h77, 16'h0310, 8'h00, 8'h05, 0, n);
        chk("np_absyw_cyc", 32'(n), 32'd3);
        idle(1);
        run(1, 3'd6, 1'b0, 8'h00, 16'h0400, 8'h01, 8'h00, 0, n);
        idle(1);
        run(1, 3'd7, 1'b0, 8'h00, 16'h0520, 8'h00, 8'h20, 0, n);
        chk("np_indy_cyc", 32'(n), 32'd4);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addr_mode_seq.md
Name: addr_mode_seq

Overview:
- Parametrised 6502-style operand/effective-address sequencer for all eight "group-one" addressing modes: IMM, ZP, ZP,X, ABS, ABS,X, ABS,Y, (ZP,X) and (ZP),Y.
- Sits between the cpu decode FSM and the memory bus. It fetches operand bytes at the PC, forms the effective address (EA), then performs the final data read or write.
- Configurable page-cross penalty, zero-page wrap and dummy-read behaviour.

Parameters:
- PAGE_PENALTY, 1: 1 = NMOS behaviour, where an indexed read costs +1 cycle only on page cross and indexed writes always cost +1; 0 = full 16-bit index add, no extra cycle ever.
- ZP_WRAP, 1: 1 = zero-page index and pointer arithmetic wraps mod 256; 0 = carry propagates into addr[15:8].
- DUMMY_RD, 1: 1 = assert rd on dummy cycles; 0 = rd low on dummy cycles (addr still driven).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin sequence; sampled only when busy=0
- mode  in  3  0 IMM, 1 ZP, 2 ZPX, 3 ABS, 4 ABSX, 5 ABSY, 6 INDX, 7 INDY
- write  in  1  final cycle is a store
- wdata  in  8  store data
- pc_in  in  16  address of first operand byte
- x  in  8  X index
- y  in  8  Y index
- d_in  in  8  memory read data, valid in the same cycle as addr
- addr  out  16  bus address
- d_out  out  8  bus write data
- rd  out  1  read strobe
- we  out  1  write strobe
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- ea  out  16  effective address
- operand  out  8  read data (IMM byte or memory byte)
- pc_out  out  16  PC after the operand bytes
- page_cross  out  1  index add crossed a page

Behaviour:
- Reset (async, any time): state IDLE; all outputs 0. An aborted sequence produces no done and no further bus activity.
- Timing: start accepted at edge E. Bus cycles C1..Cn follow; busy=1 during C1..Cn. done=1 for the cycle after Cn, with ea, operand, pc_out and page_cross stable until the next start. start is ignored while busy=1, and is accepted in the done cycle (back-to-back operation).
- Outside busy, rd, we and addr are 0. d_in is captured at the end of each read cycle.
- IMM: C1 read pc. operand = byte, ea = pc_in, pc_out = pc_in+1. If write=1, no store occurs.
- ZP: C1 read pc -> lo. C2 access {00,lo}. pc_out = +1.
- ZPX: C1 lo. C2 dummy {00,lo}. C3 access {00,lo+x}, wrap per ZP_WRAP.
- ABS: C1 lo, C2 hi, C3 access {hi,lo}. pc_out = +2.
- ABSX/ABSY (idx = x or y):
  - C1 lo, C2 hi. sum = lo+idx (9-bit).
  - C3 accesses {hi,sum[7:0]}.
  - If read and sum[8]=0, C3 is final.
  - Otherwise C3 is dummy and C4 accesses {hi+sum[8],sum[7:0]}.
  - PAGE_PENALTY=0: C3 accesses {hi,lo}+idx and is always final.
  - page_cross = sum[8].
- INDX: C1 ptr. C2 dummy {00,ptr}. C3 read lo at {00,ptr+x}. C4 read hi at {00,ptr+x+1}, wrap per ZP_WRAP. C5 access {hi,lo}. pc_out = +1.
- INDY: C1 ptr. C2 read lo at {00,ptr}. C3 read hi at {00,ptr+1}. C4/C5 follow the same rule as ABSY, using y.
- Final cycle:
  - Read: rd=1, and operand = d_in.
  - Write: we=1, d_out = wdata, rd=0, and operand is unchanged.
- Dummy cycles: rd = DUMMY_RD, we = 0.
- Address arithmetic is mod 2^16, so hi=FF with a carry gives page 00.
- Cycle counts for reads with PAGE_PENALTY=1: 1, 2, 3, 3, 3(+1), 3(+1), 5, 4(+1). Indexed writes are always 4 (ABSX/ABSY) and 5 (INDY).
- Suggested FSM states: IDLE, OP1, OP2, DUMMY, PTR_LO, PTR_HI, FIX, FINAL, DONE.

Test Plan:
- IMM read, pc_in=8000, mem[8000]=A9 -> 1 bus cycle; done with operand=A9, ea=8000, pc_out=8001.
- ZPX read, lo=F0, x=20, mem[0010]=55 -> C2 dummy at 00F0, C3 read at 0010, operand=55. With ZP_WRAP=0, C3 reads 0110 instead.
- ABSX read, lo=FF, hi=12, x=01:
  - PAGE_PENALTY=1 -> dummy read at 1200, then read at 1300; 4 cycles; page_cross=1.
  - x=00 -> 3 cycles; page_cross=0.
  - PAGE_PENALTY=0 -> 3 cycles, read at 1300.
- ABSY write, lo=10, hi=20, y=05, wdata=77 -> 4 cycles; we=1 only in C4, addr=2015, d_out=77; rd=0 in C4.
- INDX, ptr=FE, x=01, mem[00FF]=34, mem[0000]=12, mem[1234]=9C -> pointer reads at 00FF then 0000; operand=9C, ea=1234.
- INDY, ptr=40, mem[0040]=F0, mem[0041]=07, y=20 -> 5 cycles, final read at 0810.
- Reset asserted in C3 -> all outputs 0 immediately, no done; a new start afterwards runs cleanly.
- start held high while busy -> ignored; back-to-back start in the done cycle -> next C1 follows immediately.
